// File: rtl/ps2_device_tx.sv
// PS/2 keyboard emulator: queued bytes go out as start / 8 data LSB-first / odd parity / stop frames.
// Start bit two edges after a byte enters an empty idle queue; in_ready falls only while the queue is full.
module ps2_device_tx_fifo #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [7:0]    i_wdat,
    output logic [7:0]    o_rdat,
    output logic [CW-1:0] o_count
);
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push  = i_push && (r_count != CW'(DEPTH));
    assign w_pop   = i_pop && (r_count != '0);
    assign o_rdat  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

module ps2_device_tx #(
    parameter int CLK_DIV    = 16,
    parameter int GAP_CYCLES = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [7:0]                  in_data,
    output logic                        in_ready,
    output logic                        ps2_clk,
    output logic                        ps2_data,
    output logic                        busy,
    output logic                        frame_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int DW = $clog2(CLK_DIV);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_GAP
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_div_cnt;
    logic [DW-1:0] w_div_nxt;
    logic [GW-1:0] r_gap_cnt;
    logic [GW-1:0] w_gap_nxt;
    logic [3:0]    r_bit_idx;
    logic [3:0]    w_bit_nxt;
    logic [9:0]    r_shift;
    logic [9:0]    w_shift_nxt;
    logic          r_ps2_clk;
    logic          w_ps2_clk_nxt;
    logic          r_ps2_data;
    logic          w_ps2_data_nxt;
    logic          r_frame_done;
    logic          w_frame_done_nxt;
    logic          r_avail;
    logic          w_pop;
    logic [7:0]    w_head;
    logic [CW-1:0] w_count;

    ps2_device_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (in_valid),
        .i_pop   (w_pop),
        .i_wdat  (in_data),
        .o_rdat  (w_head),
        .o_count (w_count)
    );

    assign in_ready   = (w_count != CW'(FIFO_DEPTH));
    assign busy       = (r_state != S_IDLE) || (w_count != '0);
    assign fifo_count = w_count;
    assign ps2_clk    = r_ps2_clk;
    assign ps2_data   = r_ps2_data;
    assign frame_done = r_frame_done;

    // r_avail lags the count by one edge, giving the fixed two-edge accept-to-start latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_div_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '1;
            r_ps2_clk    <= 1'b1;
            r_ps2_data   <= 1'b1;
            r_frame_done <= 1'b0;
            r_avail      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_div_cnt    <= w_div_nxt;
            r_gap_cnt    <= w_gap_nxt;
            r_bit_idx    <= w_bit_nxt;
            r_shift      <= w_shift_nxt;
            r_ps2_clk    <= w_ps2_clk_nxt;
            r_ps2_data   <= w_ps2_data_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_avail      <= (w_count != '0);
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_div_nxt        = r_div_cnt;
        w_gap_nxt        = r_gap_cnt;
        w_bit_nxt        = r_bit_idx;
        w_shift_nxt      = r_shift;
        w_ps2_clk_nxt    = r_ps2_clk;
        w_ps2_data_nxt   = r_ps2_data;
        w_frame_done_nxt = 1'b0;
        w_pop            = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_ps2_clk_nxt  = 1'b1;
                w_ps2_data_nxt = 1'b1;
                if (r_avail && (w_count != '0)) begin
                    w_pop          = 1'b1;
                    w_state_nxt    = S_HIGH;
                    w_bit_nxt      = '0;
                    w_div_nxt      = '0;
                    // Remaining bits after start, LSB first: data, parity, stop.
                    w_shift_nxt    = {1'b1, ~^w_head, w_head};
                    w_ps2_data_nxt = 1'b0;
                end
            end

            S_HIGH: begin
                if (r_div_cnt == DW'(CLK_DIV - 1)) begin
                    w_state_nxt   = S_LOW;
                    w_div_nxt     = '0;
                    w_ps2_clk_nxt = 1'b0;
                end else begin
                    w_div_nxt = r_div_cnt + DW'(1);
                end
            end

            S_LOW: begin
                if (r_div_cnt == DW'(CLK_DIV - 1)) begin
                    w_div_nxt     = '0;
                    w_ps2_clk_nxt = 1'b1;
                    if (r_bit_idx != 4'd10) begin
                        w_state_nxt    = S_HIGH;
                        w_bit_nxt      = r_bit_idx + 4'd1;
                        w_ps2_data_nxt = r_shift[0];
                        w_shift_nxt    = {1'b1, r_shift[9:1]};
                    end else begin
                        w_state_nxt      = S_GAP;
                        w_gap_nxt        = '0;
                        w_ps2_data_nxt   = 1'b1;
                        w_frame_done_nxt = 1'b1;
                    end
                end else begin
                    w_div_nxt = r_div_cnt + DW'(1);
                end
            end

            S_GAP: begin
                w_ps2_clk_nxt  = 1'b1;
                w_ps2_data_nxt = 1'b1;
                if (r_gap_cnt == GW'(GAP_CYCLES - 1)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt + GW'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end
endmodule
